// File: rtl/simon_uart_tx.sv
// Simon Says event reporter.
// Buffers game events in a small FIFO, formats each one as a 5-byte ASCII
// line (letter, tens, ones, CR, LF) and hands the bytes one at a time to the
// board UART transmit port.
module simon_uart_tx #(
  parameter int DEPTH   = 4,
  parameter int ROUND_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [1:0]         ev_type,
  input  logic [ROUND_W-1:0] ev_round,
  output logic [7:0]         txdata,
  output logic               txclk,
  input  logic               txready,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = ROUND_W + 2;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, HOLD} state_t;

  state_t             state, state_nx;
  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               full, empty, push, pop;
  logic [EW-1:0]      cur_entry;
  logic [7:0]         line [5];
  logic [2:0]         idx;
  logic [15:0]        digits;

  // ASCII letter for each event code.
  function automatic logic [7:0] event_letter(input logic [1:0] code);
    logic [7:0] c;
    case (code)
      2'd0:    c = 8'h52;
      2'd1:    c = 8'h50;
      2'd2:    c = 8'h46;
      default: c = 8'h57;
    endcase
    return c;
  endfunction

  // Round number to two ASCII decimal digits, clamping anything above 99.
  function automatic logic [15:0] round_digits(input logic [ROUND_W-1:0] r);
    logic [31:0] v, t, o;
    v = 32'(r);
    if (v > 32'd99) v = 32'd99;
    t = v / 32'd10;
    o = v - t * 32'd10;
    return {8'h30 + 8'(t), 8'h30 + 8'(o)};
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign ev_ready = !full;
  assign push     = ev_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;
  assign digits   = round_digits(cur_entry[ROUND_W-1:0]);

  // FIFO storage: payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ev_type, ev_round};
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of events offered while the FIFO was full.
  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_cnt <= 8'd0;
    else if (ev_valid && full && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    if (txready) state_nx = HOLD;
      HOLD:    state_nx = (idx == 3'd4) ? IDLE : SEND;
      default: state_nx = IDLE;
    endcase
  end

  // Entry latch on pop and line formatting in LOAD (data path, not reset).
  always_ff @(posedge clk) begin
    if (pop) cur_entry <= mem[rd_ptr];
    if (state == LOAD) begin
      line[0] <= event_letter(cur_entry[EW-1:ROUND_W]);
      line[1] <= digits[15:8];
      line[2] <= digits[7:0];
      line[3] <= 8'h0D;
      line[4] <= 8'h0A;
    end
  end

  // Byte index: cleared in LOAD, advanced after each HOLD except the last.
  always_ff @(posedge clk) begin
    if (!rst_n)
      idx <= 3'd0;
    else if (state == LOAD)
      idx <= 3'd0;
    else if ((state == HOLD) && (idx != 3'd4))
      idx <= idx + 3'd1;
  end

  // UART strobe and byte: one-cycle txclk per byte, txdata held between bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txdata <= 8'h00;
      txclk  <= 1'b0;
    end else if ((state == SEND) && txready) begin
      txdata <= line[idx];
      txclk  <= 1'b1;
    end else begin
      txclk  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simon_uart_tx.sv
// Directed bench for simon_uart_tx: drives events, collects txclk bytes and
// compares them with hand-written expected lines.
module tb_simon_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic [1:0] ev_type = 2'd0;
  logic [6:0] ev_round = 7'd0;
  logic [7:0] txdata;
  logic       txclk;
  logic       txready = 1'b1;
  logic       busy;
  logic [7:0] drop_cnt;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int dbl = 0;
  logic prev_txclk = 1'b0;
  logic [7:0] q[$];
  int pc[$];
  int p_edge;

  simon_uart_tx #(.DEPTH(4), .ROUND_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_type(ev_type), .ev_round(ev_round), .txdata(txdata), .txclk(txclk),
    .txready(txready), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Edge counter.
  always @(posedge clk) cyc++;

  // Byte collector: records every txclk pulse and flags back-to-back pulses.
  always @(negedge clk) begin
    if (txclk) begin
      q.push_back(txdata);
      pc.push_back(cyc);
      if (prev_txclk) dbl++;
    end
    prev_txclk = txclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_line(input string s, input int base, input string tag);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(q[base+i]), 32'(s.getc(i)));
    chk($sformatf("%s_cr", tag), 32'(q[base+3]), 32'h0D);
    chk($sformatf("%s_lf", tag), 32'(q[base+4]), 32'h0A);
  endtask

  task automatic send_ev(input logic [1:0] t, input logic [6:0] r);
    @(negedge clk);
    ev_valid = 1'b1; ev_type = t; ev_round = r;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_txdata", 32'(txdata), 32'h00);
    chk("rst_txclk", 32'(txclk), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ready", 32'(ev_ready), 32'd1);
    rst_n = 1'b1;

    // 1: single ROUND 7 line, latency and byte spacing
    repeat (2) @(negedge clk);
    #1; q.delete(); pc.delete();
    send_ev(2'd0, 7'd7);
    p_edge = cyc + 1;
    @(negedge clk); ev_valid = 1'b0;
    wait_bytes(5, 60, "t1_wait");
    check_line("R07", 0, "t1");
    chk("t1_latency", 32'((pc[0] - p_edge) <= 4), 32'd1);
    for (int i = 1; i < 5; i++)
      chk($sformatf("t1_gap%0d", i), 32'(pc[i] - pc[i-1]), 32'd2);
    @(negedge clk);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_hold_lf", 32'(txdata), 32'h0A);

    // 2: clamp and zero, two lines in order
    #1; q.delete();
    send_ev(2'd2, 7'd120);
    send_ev(2'd3, 7'd0);
    @(negedge clk); ev_valid = 1'b0;
    wait_bytes(10, 100, "t2_wait");
    check_line("F99", 0, "t2a");
    check_line("W00", 5, "t2b");
    wait_idle(20, "t2_idle");

    // 3: txready low after first byte
    q.delete();
    send_ev(2'd0, 7'd5);
    @(negedge clk); ev_valid = 1'b0;
    wait_bytes(1, 40, "t3_first");
    txready = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("t3_stall_cnt", 32'(q.size()), 32'd1);
    chk("t3_stall_data", 32'(txdata), 32'h52);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    txready = 1'b1;
    wait_bytes(5, 40, "t3_rest");
    check_line("R05", 0, "t3");
    wait_idle(20, "t3_idle");

    // 4: overflow with txready low
    q.delete();
    txready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) chk("t4_ready_before_full", 32'(ev_ready), 32'd1);
      if (i == 5) chk("t4_ready_full", 32'(ev_ready), 32'd0);
      ev_valid = 1'b1;
      ev_type = 2'(i % 4);
      ev_round = 7'(10 + i);
    end
    @(negedge clk); ev_valid = 1'b0;
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    chk("t4_still_full", 32'(ev_ready), 32'd0);
    chk("t4_no_bytes", 32'(q.size()), 32'd0);
    txready = 1'b1;
    wait_bytes(25, 400, "t4_wait");
    check_line("R10", 0, "t4a");
    check_line("P11", 5, "t4b");
    check_line("F12", 10, "t4c");
    check_line("W13", 15, "t4d");
    check_line("R14", 20, "t4e");
    wait_idle(40, "t4_idle");

    // 5: push in the same cycle IDLE pops the single buffered entry
    q.delete();
    send_ev(2'd0, 7'd21);
    send_ev(2'd3, 7'd22);
    @(negedge clk); ev_valid = 1'b0;
    chk("t5_ready", 32'(ev_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_bytes(10, 100, "t5_wait");
    check_line("R21", 0, "t5a");
    check_line("W22", 5, "t5b");
    chk("t5_drop_kept", 32'(drop_cnt), 32'd1);
    wait_idle(20, "t5_idle");

    // 6: reset mid-line after byte 2
    q.delete();
    send_ev(2'd2, 7'd33);
    @(negedge clk); ev_valid = 1'b0;
    wait_bytes(2, 40, "t6_two");
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_txclk", 32'(txclk), 32'd0);
    chk("t6_txdata", 32'(txdata), 32'h00);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("t6_no_more", 32'(q.size()), 32'd2);
    chk("t6_first", 32'(q[0]), 32'h46);
    chk("t6_second", 32'(q[1]), 32'h33);

    chk("no_double_txclk", 32'(dbl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
